// File: rtl/ntt_core_gf64_head_buf.sv
// ntt_core_gf64_head_buf: input head of the gf64 NTT core.
// Widens decomposed coefficients to OUT_W, buffers them with framing and
// pbs_id in a DEPTH-entry FIFO, and flags lane and framing inconsistencies.
//
// Ports:
//   clk, s_rst_n        clock, asynchronous active-low reset
//   in_data[L*IN_W]     coefficients, lane-major [PSI][R]
//   in_data_vld/rdy     per-lane valid / ready (ready bits identical)
//   in_sob..in_eog      framing flags
//   in_pbs_id           PBS identifier
//   in_ctrl_vld/rdy     control valid / ready
//   out_data[L*OUT_W]   converted coefficients of the head entry
//   out_sob..out_eos    framing flags (sog/eog renamed sos/eos)
//   out_pbs_id          PBS identifier of the head entry
//   out_vld/out_rdy     output handshake
//   occupancy           FIFO fill level
//   error[1:0]          [0] lane mismatch, [1] framing violation
//
// Optional feature: define NTT_CORE_GF64_HEAD_NEG_FOLD_EN to store negative
// signed inputs as p+x (p = 2^64-2^32+1) instead of sign-extending them.

module ntt_core_gf64_head_buf #(
   parameter int PSI       = 8,
   parameter int R         = 2,
   parameter int IN_W      = 10,
   parameter int OUT_W     = 66,
   parameter int SIGNED_IN = 1,
   parameter int ID_W      = 8,
   parameter int DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          s_rst_n,

   input  logic [PSI*R*IN_W-1:0]         in_data,
   input  logic [PSI*R-1:0]              in_data_vld,
   output logic [PSI*R-1:0]              in_data_rdy,
   input  logic                          in_sob,
   input  logic                          in_eob,
   input  logic                          in_sol,
   input  logic                          in_eol,
   input  logic                          in_sog,
   input  logic                          in_eog,
   input  logic [ID_W-1:0]               in_pbs_id,
   input  logic                          in_ctrl_vld,
   output logic                          in_ctrl_rdy,

   output logic [PSI*R*OUT_W-1:0]        out_data,
   output logic                          out_sob,
   output logic                          out_eob,
   output logic                          out_sol,
   output logic                          out_eol,
   output logic                          out_sos,
   output logic                          out_eos,
   output logic [ID_W-1:0]               out_pbs_id,
   output logic                          out_vld,
   input  logic                          out_rdy,

   output logic [$clog2(DEPTH):0]        occupancy,
   output logic [1:0]                    error
);

   localparam int L     = PSI * R;
   localparam int AW    = $clog2(DEPTH);
   localparam int OCC_W = AW + 1;

`ifdef NTT_CORE_GF64_HEAD_NEG_FOLD_EN
   localparam logic [63:0] GF_P = 64'hFFFF_FFFF_0000_0001;
`endif

   // Storage: one entry = all lanes + six flags + pbs_id
   logic [L*OUT_W-1:0] mem_data [DEPTH];
   logic [5:0]         mem_flag [DEPTH];
   logic [ID_W-1:0]    mem_id   [DEPTH];

   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [OCC_W-1:0]   occ_q;
   logic [OCC_W-1:0]   occ_nxt;
   logic               rdy_q;
   logic               batch_open;
   logic [1:0]         err_q;

   logic               push;
   logic               pop;
   logic               any_vld;
   logic               all_vld;
   logic               lane_err;
   logic               frame_err;
   logic [L*OUT_W-1:0] wr_data;
   logic [5:0]         wr_flag;

   // Per-lane widening to the datapath width
   function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] x);
      logic [OUT_W-1:0] ext;
`ifdef NTT_CORE_GF64_HEAD_NEG_FOLD_EN
      logic [63:0]      fold;
`endif
      if (SIGNED_IN != 0)
         ext = {{(OUT_W-IN_W){x[IN_W-1]}}, x};
      else
         ext = {{(OUT_W-IN_W){1'b0}}, x};
`ifdef NTT_CORE_GF64_HEAD_NEG_FOLD_EN
      // p + x computed mod 2^64 from the sign-extended value
      fold = ext[63:0] + GF_P;
      if ((SIGNED_IN != 0) && x[IN_W-1]) begin
         conv       = '0;
         conv[63:0] = fold;
      end else begin
         conv = ext;
      end
`else
      conv = ext;
`endif
   endfunction

   always_comb begin
      wr_data = '0;
      for (int k = 0; k < L; k++)
         wr_data[k*OUT_W +: OUT_W] = conv(in_data[k*IN_W +: IN_W]);
   end

   assign wr_flag = {in_sob, in_eob, in_sol, in_eol, in_sog, in_eog};

   // Handshake and consistency checks
   assign any_vld  = |in_data_vld;
   assign all_vld  = &in_data_vld;
   assign push     = all_vld & in_ctrl_vld & rdy_q;
   assign pop      = out_vld & out_rdy;
   assign lane_err = (any_vld & ~all_vld) | (any_vld != in_ctrl_vld);

   // sob+eob together is a single-entry batch and never opens one
   assign frame_err = (in_sob & batch_open) |
                      (in_eob & ~batch_open & ~(in_sob & in_eob));

   always_comb begin
      occ_nxt = occ_q;
      unique case (1'b1)
         (push & ~pop): occ_nxt = occ_q + OCC_W'(1);
         (pop & ~push): occ_nxt = occ_q - OCC_W'(1);
         default:       occ_nxt = occ_q;
      endcase
   end

   // Pointers, occupancy, registered ready, batch state, errors
   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ_q      <= '0;
         rdy_q      <= 1'b1;
         batch_open <= 1'b0;
         err_q      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         occ_q    <= occ_nxt;
         // ready depends only on state, never on out_rdy this cycle
         rdy_q    <= (occ_nxt < OCC_W'(DEPTH));
         if (push) begin
            if (in_eob)
               batch_open <= 1'b0;
            else if (in_sob)
               batch_open <= 1'b1;
         end
         err_q[0] <= lane_err;
         err_q[1] <= push & frame_err;
      end
   end

   // Entry storage; cleared on reset so the idle head reads as zero
   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_flag[i] <= '0;
            mem_id[i]   <= '0;
         end
      end else if (push) begin
         mem_data[wr_ptr] <= wr_data;
         mem_flag[wr_ptr] <= wr_flag;
         mem_id[wr_ptr]   <= in_pbs_id;
      end
   end

   assign in_data_rdy = {L{rdy_q}};
   assign in_ctrl_rdy = rdy_q;

   assign out_vld    = (occ_q != '0);
   assign out_data   = mem_data[rd_ptr];
   assign out_sob    = mem_flag[rd_ptr][5];
   assign out_eob    = mem_flag[rd_ptr][4];
   assign out_sol    = mem_flag[rd_ptr][3];
   assign out_eol    = mem_flag[rd_ptr][2];
   assign out_sos    = mem_flag[rd_ptr][1];
   assign out_eos    = mem_flag[rd_ptr][0];
   assign out_pbs_id = mem_id[rd_ptr];

   assign occupancy = occ_q;
   assign error     = err_q;

endmodule
